// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and FSM state type for the TDM demultiplexer.
package tdm_pkg;

  localparam int SLOT_W = 3;
  localparam int NCH    = 1 << SLOT_W;

  // HUNT: waiting for a frame_sync beat; ACTIVE: aligned and accumulating.
  typedef enum logic {
    HUNT   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: SLOT_W-bit wrapping slot index.
// load0 means "the current beat is slot 0", so the next expected slot is 1.
// It takes priority over inc. Wrap-around relies on NCH == 2**SLOT_W.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int SLOT_W = tdm_pkg::SLOT_W,
  parameter int NCH    = tdm_pkg::NCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load0,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  // Slot index register: realign to 1, or step with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (load0) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + 1'b1;
    end
  end

  assign last = (slot == SLOT_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: serial-to-parallel TDM demultiplexer.
// Rebuilds one NCH-bit word per frame from a slot-ordered serial stream.
// dout_valid pulses for one cycle when the frame completes.
//
// Handshake: a beat is consumed on every rising edge where din_valid = 1.
// There is no back-pressure. frame_sync is only looked at on such beats.
// dout_valid is a one-cycle strobe with no ready.
//
// Optional macro TDM_DEMUX_SYNC_CHECK_EN enables misaligned-sync detection.
// A frame_sync beat at slot != 0 while ACTIVE then pulses sync_err. It also
// drops the partial frame and restarts alignment on that beat. Without the
// macro, frame_sync is ignored once ACTIVE.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int SLOT_W = tdm_pkg::SLOT_W,
  parameter int NCH    = tdm_pkg::NCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NCH-1:0]    dout,
  output logic              dout_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  ,
  output logic              sync_err
`endif
);

  state_t         state;
  logic [NCH-1:0] acc;
  logic           last;
  logic           inc;
  logic           load0;
  logic           misalign;

  // A sync beat landing anywhere but slot 0 while aligned.
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign misalign = din_valid && frame_sync && (state == ACTIVE) && (slot != '0);
`else
  assign misalign = 1'b0;
`endif

  assign load0 = misalign;
  assign inc   = din_valid && ((state == ACTIVE) || frame_sync);

  tdm_slot_counter #(
    .SLOT_W (SLOT_W),
    .NCH    (NCH)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .load0 (load0),
    .slot  (slot),
    .last  (last)
  );

  // FSM, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      locked     <= 1'b0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      sync_err   <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      sync_err   <= 1'b0;
`endif
      case (state)
        HUNT: begin
          if (din_valid && frame_sync) begin
            acc[0] <= din;
            state  <= ACTIVE;
            locked <= 1'b1;
          end
        end
        ACTIVE: begin
          if (misalign) begin
            // Drop the partial frame and treat this beat as slot 0.
            acc <= {{(NCH - 1){1'b0}}, din};
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            sync_err <= 1'b1;
`endif
          end else if (din_valid) begin
            acc[slot] <= din;
            if (last) begin
              dout       <= {din, acc[NCH-2:0]};
              dout_valid <= 1'b1;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed table vectors, hand-written corner sequences and
// randomized beats checked against a slot-level reference model.
module tb_tdm_demux8;
  import tdm_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              din;
  logic              din_valid;
  logic              frame_sync;
  logic [NCH-1:0]    dout;
  logic              dout_valid;
  logic [SLOT_W-1:0] slot;
  logic              locked;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic              sync_err;
  localparam bit SYNC_CHK = 1'b1;
`else
  localparam bit SYNC_CHK = 1'b0;
`endif

  // Clock
  always #5 clk = ~clk;

  tdm_demux8 dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked)
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    ,
    .sync_err   (sync_err)
`endif
  );

  // Counters and scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int err_cnt = 0;
  logic [NCH-1:0] exp_q[$];
  int             pulse_cyc[$];
  logic [NCH-1:0] last_word;

  // Reference model: position within frame plus collected bits per slot
  bit             m_locked;
  int             m_pos;
  int             m_bits[NCH];
  bit             m_valid;
  bit             m_err;
  logic [NCH-1:0] m_dout;

  typedef struct {
    logic [0:NCH-1] seq;   // din per slot, slot 0 leftmost
    int             gap_at;
    int             gap_len;
    logic [NCH-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    for (int i = 0; i < NCH; i++) m_bits[i] = 0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_dout   = '0;
    exp_q.delete();
  endfunction

  function automatic void model_beat(logic d, logic v, logic fs);
    int w;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (v !== 1'b1) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked  = 1'b1;
        m_bits[0] = int'(d);
        m_pos     = 1;
      end
    end else if (SYNC_CHK && fs && m_pos != 0) begin
      m_err = 1'b1;
      for (int i = 0; i < NCH; i++) m_bits[i] = 0;
      m_bits[0] = int'(d);
      m_pos     = 1;
    end else begin
      m_bits[m_pos] = int'(d);
      m_pos++;
      if (m_pos == NCH) begin
        w = 0;
        for (int i = 0; i < NCH; i++) w += m_bits[i] * (1 << i);
        m_dout  = NCH'(w);
        m_valid = 1'b1;
        exp_q.push_back(NCH'(w));
        m_pos   = 0;
      end
    end
  endfunction

  function automatic void check_all();
    chk("slot", 32'(slot), 32'(m_pos));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", 32'(dout), 32'(m_dout));
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    chk("sync_err", 32'(sync_err), 32'(m_err));
    if (sync_err === 1'b1) err_cnt++;
`endif
    if (dout_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      last_word = dout;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_word: got %0h expected no word (cycle %0d)", dout, cyc);
      end else begin
        logic [NCH-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_bad++;
          $display("FAIL sb_word: got %0h expected %0h (cycle %0d)", dout, e, cyc);
        end
      end
    end
  endfunction

  // Driver: one clock with the given inputs, then update model and check.
  task automatic step(input logic d, input logic v, input logic fs);
    din        = d;
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    cyc++;
    model_beat(d, v, fs);
    #1;
    check_all();
  endtask

  // Reset with all other inputs active to exercise reset priority.
  task automatic do_reset();
    rst        = 1'b1;
    din        = 1'b1;
    din_valid  = 1'b1;
    frame_sync = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    check_all();
  endtask

  task automatic send_seq(input logic [0:NCH-1] seq, input int gap_at, input int gap_len);
    for (int i = 0; i < NCH; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
          chk("gap_slot", 32'(slot), 32'(i));
        end
      end
      step(seq[i], 1'b1, i == 0);
    end
  endtask

  initial begin
    tbl[0] = '{seq: 8'b0011_1100, gap_at: 99, gap_len: 0, exp: 8'h3C};
    tbl[1] = '{seq: 8'b1011_0010, gap_at: 99, gap_len: 0, exp: 8'h4D};
    tbl[2] = '{seq: 8'b1010_0101, gap_at: 4,  gap_len: 5, exp: 8'hA5};
    tbl[3] = '{seq: 8'b1111_0000, gap_at: 1,  gap_len: 2, exp: 8'h0F};
    tbl[4] = '{seq: 8'b0000_0001, gap_at: 7,  gap_len: 3, exp: 8'h80};
    tbl[5] = '{seq: 8'b1101_0000, gap_at: 99, gap_len: 0, exp: 8'h0B};

    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    last_word = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // HUNT filtering: valid beats without frame_sync are ignored.
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      chk("hunt_locked", 32'(locked), 32'h0);
    end

    // Table vectors (first entry is the synced frame leaving HUNT).
    for (int k = 0; k < 6; k++) begin
      send_seq(tbl[k].seq, tbl[k].gap_at, tbl[k].gap_len);
      chk("vec_valid", 32'(dout_valid), 32'h1);
      chk("vec_dout", 32'(dout), 32'(tbl[k].exp));
    end
    step(1'b0, 1'b0, 1'b0);
    chk("dout_hold", 32'(dout), 32'h0B);

    // Back-to-back frames with din_valid held high.
    pulse_cyc.delete();
    send_seq(8'b1111_1111, 99, 0);
    chk("b2b_first", 32'(last_word), 32'hFF);
    send_seq(8'b1000_0000, 99, 0);
    chk("b2b_second", 32'(last_word), 32'h01);
    chk("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) chk("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd8);

    // Reset mid-frame, then a clean frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset();
    send_seq(8'b0110_0110, 99, 0);
    chk("post_rst_dout", 32'(dout), 32'h66);

    // Misaligned sync at slot 5, followed by a 0x81 frame.
    err_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
    send_seq(8'b1000_0001, 99, 0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    chk("mis_dout", 32'(last_word), 32'h81);
    chk("mis_err_cnt", 32'(err_cnt), 32'd1);
`else
    chk("mis_dout", 32'(last_word), 32'h3F);
    chk("mis_slot", 32'(slot), 32'd5);
`endif

    // Randomized beats against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
    end
    chk("rand_sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
